pwm_breathe: RTL and testbench

Multi-channel LED breathing controller: one shared free-running PWM counter drives CHANNELS comparators, each fed by its own brightness level that ramps automatically at a prescaled rate in triangle (up/down) or sawtooth (up, wrap) mode. It sits between the board clock and the LED pins, replacing per-design glue that pokes a single PWM instance. Channel start levels are staggered so the channels breathe out of phase. Duty updates are glitch-free: each channel's duty is applied only at the PWM period boundary.

---
 rtl/pwm_breathe.sv | 124 ++++++++++++
 tb/tb_pwm_breathe.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pwm_breathe.sv
// pwm_breathe: multi-channel LED breathing controller built on one shared free-running PWM counter.
// Latency: LED, period_start and step are registered, one cycle after the counter state that produces them.
// Backpressure: none. en=0 freezes all state and drives the LEDs inactive from the next cycle.
//
// Ports:
//   CLK          system clock; all state changes on its rising edge
//   RST_N        asynchronous active-low reset
//   en           run enable
//   mode         0 = triangle ramp, 1 = sawtooth ramp
//   LED          registered PWM outputs, one per channel (inverted when ACTIVE_LOW)
//   period_start one-cycle pulse after the PWM counter wraps to 0
//   step         one-cycle pulse after each prescaler tick
//
// Optional feature: define PWM_BREATHE_GAMMA_EN to square the level before it is
// loaded as duty, which gives perceptual brightness. Without it, duty equals level.
module pwm_breathe #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int PRESCALE   = 65536,
  parameter int MAX_LEVEL  = 128,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                en,
  input  logic                mode,
  output logic [CHANNELS-1:0] LED,
  output logic                period_start,
  output logic                step
);

  // Prescaler width. Keep at least one bit so that PRESCALE=1 still elaborates.
  localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] LVL_MAX   = WIDTH'(MAX_LEVEL);
  localparam logic            LED_OFF    = (ACTIVE_LOW != 0);

  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] pwm_cnt;
  logic [WIDTH-1:0] level     [CHANNELS];
  logic [WIDTH-1:0] level_nxt [CHANNELS];
  logic [WIDTH-1:0] duty      [CHANNELS];
  logic [CHANNELS-1:0] dir;      // 0 = ramping up, 1 = ramping down
  logic [CHANNELS-1:0] dir_nxt;
  logic tick;
  logic wrap;

  assign tick = en && (presc == PRESC_LAST);
  assign wrap = en && (pwm_cnt == CNT_LAST);

  function automatic logic [WIDTH-1:0] shaped(input logic [WIDTH-1:0] l);
`ifdef PWM_BREATHE_GAMMA_EN
    logic [2*WIDTH-1:0] sq;
    sq = {{WIDTH{1'b0}}, l} * {{WIDTH{1'b0}}, l};
    return sq[2*WIDTH-1:WIDTH];
`else
    return l;
`endif
  endfunction

  // Ramp step. Turnaround happens on the tick that finds the level at an
  // end point, so the ramp never dwells at 0 or MAX_LEVEL. Sawtooth leaves
  // dir untouched so a return to triangle continues in the old direction.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      level_nxt[i] = level[i];
      dir_nxt[i]   = dir[i];
      if (mode) begin
        level_nxt[i] = (level[i] == LVL_MAX) ? '0 : level[i] + WIDTH'(1);
      end else if (!dir[i]) begin
        if (level[i] == LVL_MAX) begin
          dir_nxt[i]   = 1'b1;
          level_nxt[i] = level[i] - WIDTH'(1);
        end else begin
          level_nxt[i] = level[i] + WIDTH'(1);
        end
      end else begin
        if (level[i] == '0) begin
          dir_nxt[i]   = 1'b0;
          level_nxt[i] = level[i] + WIDTH'(1);
        end else begin
          level_nxt[i] = level[i] - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc        <= '0;
      pwm_cnt      <= '0;
      dir          <= '0;
      LED          <= {CHANNELS{LED_OFF}};
      period_start <= 1'b0;
      step         <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        // Staggered start levels put the channels out of phase.
        level[i] <= WIDTH'((i * MAX_LEVEL) / CHANNELS);
        duty[i]  <= '0;
      end
    end else begin
      period_start <= wrap;
      step         <= tick;
      if (en) begin
        presc   <= tick ? '0 : presc + PW'(1);
        pwm_cnt <= pwm_cnt + WIDTH'(1);
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (tick) begin
          level[i] <= level_nxt[i];
          dir[i]   <= dir_nxt[i];
        end
        // Duty only changes at the period boundary, so a period is never cut
        // short or stretched. A coincident tick loads the pre-update level.
        if (wrap) begin
          duty[i] <= shaped(level[i]);
        end
        LED[i] <= en ? ((pwm_cnt < duty[i]) ^ LED_OFF) : LED_OFF;
      end
    end
  end

endmodule

// File: tb/tb_pwm_breathe.sv
// Testbench for pwm_breathe (WIDTH=4, CHANNELS=2, PRESCALE=4, MAX_LEVEL=8, ACTIVE_LOW=1).
// The driver pushes the expected per-period LED on-counts and step count for each PWM period;
// the monitor accumulates what the DUT shows and pops and compares on every period_start.
module tb_pwm_breathe;

  logic       CLK;
  logic       RST_N;
  logic       en;
  logic       mode;
  logic [1:0] LED;
  logic       period_start;
  logic       step;

  pwm_breathe #(
    .CHANNELS  (2),
    .WIDTH     (4),
    .PRESCALE  (4),
    .MAX_LEVEL (8),
    .ACTIVE_LOW(1)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .en          (en),
    .mode        (mode),
    .LED         (LED),
    .period_start(period_start),
    .step        (step)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int on0;
    int on1;
    int steps;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   errors;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Duty produced from a level; squared when the gamma option is built in.
  function automatic int shp(input int l);
`ifdef PWM_BREATHE_GAMMA_EN
    return (l * l) >> 4;
`else
    return l;
`endif
  endfunction

  // Expected activity of one PWM period given the levels that were loaded as duty.
  task automatic push_exp(input int l0, input int l1);
    exp_t e;
    e.on0   = shp(l0);
    e.on1   = shp(l1);
    e.steps = 4;
    q.push_back(e);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    int   on0, on1, stp, cyc;
    bit   first_seen;
    exp_t e;
    on0 = 0; on1 = 0; stp = 0; cyc = 0; first_seen = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (!RST_N) begin
        chk("reset_led", int'(LED), 3);
        chk("reset_period_start", int'(period_start), 0);
        chk("reset_step", int'(step), 0);
        on0 = 0; on1 = 0; stp = 0; cyc = 0; first_seen = 0;
      end else begin
        if (!en) begin
          chk("disabled_led", int'(LED), 3);
          chk("disabled_period_start", int'(period_start), 0);
          chk("disabled_step", int'(step), 0);
        end
        if (LED[0] == 1'b0) on0++;
        if (LED[1] == 1'b0) on1++;
        if (step) stp++;
        if (period_start) begin
          if (!first_seen) begin
            chk("first_period_start_cycle", cyc, 15);
            first_seen = 1;
          end
          if (q.size() == 0) begin
            chk("unexpected_period_start", 1, 0);
          end else begin
            e = q.pop_front();
            chk("period_on_ch0", on0, e.on0);
            chk("period_on_ch1", on1, e.on1);
            chk("period_steps", stp, e.steps);
          end
          on0 = 0; on1 = 0; stp = 0;
        end
        cyc++;
      end
    end
  end

  task automatic do_reset(input bit m);
    RST_N = 1'b0;
    en    = 1'b1;
    mode  = m;
    repeat (4) @(negedge CLK);
    chk("queue_drained_before_reset_release", q.size(), 0);
    RST_N = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST_N  = 1'b0;
    en     = 1'b1;
    mode   = 1'b0;
    @(negedge CLK);

    // Phase 1: triangle, with a 50-cycle disable in the middle of period 3.
    // ch0 from 0, ch1 from 4; duty = level after 3,7,11,... ticks.
    do_reset(1'b0);
    push_exp(0, 0);
    push_exp(3, 7);
    push_exp(7, 5);
    push_exp(5, 1);
    push_exp(1, 3);
    push_exp(3, 7);
    push_exp(7, 5);
    push_exp(5, 1);
    for (int k = 0; k < 178; k++) begin
      @(negedge CLK);
      if (k == 52)  en = 1'b0;
      if (k == 102) en = 1'b1;
    end

    // Phase 2: sawtooth from reset (period 9 ramp), reset again mid-period.
    do_reset(1'b1);
    push_exp(0, 0);
    push_exp(3, 7);
    push_exp(7, 2);
    push_exp(2, 6);
    push_exp(6, 1);
    push_exp(1, 5);
    for (int k = 0; k < 103; k++) @(negedge CLK);

    // Phase 3: triangle until ch0 is descending at 7, sawtooth for ticks 10..13
    // (ch0 7->8->0->1->2), then triangle again: ch0 keeps its down direction.
    do_reset(1'b0);
    push_exp(0, 0);
    push_exp(3, 7);
    push_exp(7, 5);
    push_exp(0, 5);
    push_exp(0, 5);
    push_exp(4, 1);
    push_exp(8, 3);
    for (int k = 0; k < 112; k++) begin
      @(negedge CLK);
      if (k == 37) mode = 1'b1;
      if (k == 53) mode = 1'b0;
    end

    repeat (3) @(negedge CLK);
    chk("queue_drained_at_end", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
